// File: rtl/seq_mul_nbit.sv
// seq_mul_nbit: shift-add WIDTH x WIDTH -> 2*WIDTH sequential multiplier with start/busy/done handshake.
// Define SEQ_MUL_SIGNED_EN to enable two's-complement operands selected by sgn.
module seq_mul_nbit #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   op
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     a_r;
  logic [2*WIDTH:0]     p_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   op_r;

  logic [WIDTH:0]       addend_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH:0]     p_next_s;
  logic [WIDTH-1:0]     a_mag_s;
  logic [WIDTH-1:0]     b_mag_s;
  logic [2*WIDTH-1:0]   result_s;

  // One partial-product step: conditional add into the upper half, then shift right keeping the carry.
  always_comb begin
    addend_s = {(WIDTH+1){1'b0}};
    if (p_r[0]) begin
      addend_s = {1'b0, a_r};
    end else begin
      addend_s = {(WIDTH+1){1'b0}};
    end
    sum_s    = p_r[2*WIDTH:WIDTH] + addend_s;
    p_next_s = {1'b0, sum_s, p_r[WIDTH-1:1]};
  end

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_s;
  logic neg_r;

  // Signed mode: feed magnitudes to the unsigned core and re-apply the sign at completion.
  always_comb begin
    neg_s = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    if (sgn && a[WIDTH-1]) begin
      a_mag_s = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      a_mag_s = a;
    end
    if (sgn && b[WIDTH-1]) begin
      b_mag_s = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      b_mag_s = b;
    end
    if (neg_r) begin
      result_s = ~p_next_s[2*WIDTH-1:0] + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = p_next_s[2*WIDTH-1:0];
    end
  end

  // Sign of the product, captured together with the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      neg_r <= neg_s;
    end else begin
      neg_r <= neg_r;
    end
  end
`else
  logic unused_sgn_s;
  assign unused_sgn_s = sgn;

  // Unsigned-only build: operands pass straight through.
  always_comb begin
    a_mag_s  = a;
    b_mag_s  = b;
    result_s = p_next_s[2*WIDTH-1:0];
  end
`endif

  // Control FSM and datapath registers; op only changes on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      a_r     <= {WIDTH{1'b0}};
      p_r     <= {(2*WIDTH+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      op_r    <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a_mag_s;
            p_r     <= {{(WIDTH+1){1'b0}}, b_mag_s};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_r   <= p_next_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CW'(WIDTH-1)) begin
            op_r    <= result_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign op   = op_r;

endmodule
